// File: rtl/life_ctrl_if.sv
// life_ctrl_if: request/response bundle between the board controls, the
// life_ctrl sequencer and the torus shift chain.
//   master : board controls / torus side (drives requests and torus_last)
//   slave  : the sequencer (drives seed chain and step pulses)
interface life_ctrl_if #(
  parameter int DIV_W = 24,
  parameter int GEN_W = 16
);
  logic             load_req;
  logic             recirc;
  logic             ext_seed;
  logic             run;
  logic             step_req;
  logic [DIV_W-1:0] period;
  logic             torus_last;
  logic             seed;
  logic             seed_ena;
  logic             life_step;
  logic [GEN_W-1:0] gen_count;
  logic             busy;
  logic             load_done;

  modport master (
    output load_req, recirc, ext_seed, run, step_req, period, torus_last,
    input  seed, seed_ena, life_step, gen_count, busy, load_done
  );

  modport slave (
    input  load_req, recirc, ext_seed, run, step_req, period, torus_last,
    output seed, seed_ena, life_step, gen_count, busy, load_done
  );
endinterface

// File: rtl/life_ctrl.sv
// life_ctrl: Game-of-Life torus sequencer.
// Loads one full W*H frame through the serial seed chain (external bit,
// internal LFSR, or recirculated torus_last), then issues generation pulses
// either free-running at a programmable period or as single steps.
// Optional feature: define LIFE_CTRL_LFSR_EN to seed from a 16-bit Galois
// LFSR instead of ext_seed.
module life_ctrl #(
  parameter int TORUS_WIDTH  = 32,
  parameter int TORUS_HEIGHT = 32,
  parameter int DIV_W        = 24,
  parameter int GEN_W        = 16
) (
  input logic        clk,
  input logic        rst_n,
  life_ctrl_if.slave bus
);
  localparam int N     = TORUS_WIDTH * TORUS_HEIGHT;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             recirc_q, recirc_d;
  logic             seed_ena_q, seed_ena_d;
  logic             step_q, step_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DIV_W-1:0] last_tick;
  logic             source_bit;

  // A period of 0 behaves like 1, so the terminal prescaler value saturates at 0.
  assign last_tick = (bus.period == '0) ? '0 : bus.period - DIV_W'(1);

`ifdef LIFE_CTRL_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        unused_ext_seed;

  assign unused_ext_seed = bus.ext_seed;
  assign source_bit      = lfsr_q[0];

  // Galois right-shift LFSR; only advances while it is actually feeding the chain.
  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_ena_q && !recirc_q)
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // LFSR register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end
`else
  assign source_bit = bus.ext_seed;
`endif

  // Next-state and registered-output logic; load_req beats run beats step_req.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    presc_d    = presc_q;
    gen_d      = gen_q;
    recirc_d   = recirc_q;
    seed_ena_d = 1'b0;
    step_d     = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_req) begin
          state_d    = LOAD;
          cnt_d      = N_CNT;
          recirc_d   = bus.recirc;
          seed_ena_d = 1'b1;
          busy_d     = 1'b1;
          presc_d    = '0;
          if (!bus.recirc) gen_d = '0;
        end else if (bus.run) begin
          state_d = RUN;
          presc_d = '0;
        end else if (bus.step_req) begin
          step_d = 1'b1;
          gen_d  = gen_q + GEN_W'(1);
        end
      end
      LOAD: begin
        // Requests are ignored here; the frame must be shifted in completely.
        seed_ena_d = 1'b1;
        busy_d     = 1'b1;
        cnt_d      = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          seed_ena_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          presc_d    = '0;
          state_d    = bus.run ? RUN : IDLE;
        end
      end
      RUN: begin
        if (bus.load_req) begin
          state_d    = LOAD;
          cnt_d      = N_CNT;
          recirc_d   = bus.recirc;
          seed_ena_d = 1'b1;
          busy_d     = 1'b1;
          presc_d    = '0;
          if (!bus.recirc) gen_d = '0;
        end else if (!bus.run) begin
          state_d = IDLE;
          presc_d = '0;
        end else if (presc_q >= last_tick) begin
          // >= rather than == so a shortened period takes effect at once.
          step_d  = 1'b1;
          presc_d = '0;
          gen_d   = gen_q + GEN_W'(1);
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      presc_q    <= '0;
      gen_q      <= '0;
      recirc_q   <= 1'b0;
      seed_ena_q <= 1'b0;
      step_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      presc_q    <= presc_d;
      gen_q      <= gen_d;
      recirc_q   <= recirc_d;
      seed_ena_q <= seed_ena_d;
      step_q     <= step_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // seed stays combinational so rotation adds no delay around the torus loop.
  assign bus.seed      = recirc_q ? bus.torus_last : source_bit;
  assign bus.seed_ena  = seed_ena_q;
  assign bus.life_step = step_q;
  assign bus.gen_count = gen_q;
  assign bus.busy      = busy_q;
  assign bus.load_done = done_q;
endmodule

// File: tb/tb_life_ctrl.sv
// tb_life_ctrl: randomized + directed bench for life_ctrl on a 4x4 torus,
// with a cycle-level behavioural reference model and a torus shift-chain model.
module tb_life_ctrl;
  localparam int TW = 4, TH = 4, N = TW * TH, DIV_W = 8, GEN_W = 4;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2;

  logic gclk = 1'b0;
  logic grst_n = 1'b0;
  always #5 gclk = ~gclk;

  life_ctrl_if #(.DIV_W(DIV_W), .GEN_W(GEN_W)) bus ();

  life_ctrl #(.TORUS_WIDTH(TW), .TORUS_HEIGHT(TH), .DIV_W(DIV_W), .GEN_W(GEN_W)) dut (
    .clk(gclk), .rst_n(grst_n), .bus(bus.slave)
  );

  // Torus shift chain stand-in.
  logic [N-1:0] torus = '0;
  always @(posedge gclk) if (bus.seed_ena) torus <= {torus[N-2:0], bus.seed};
  assign bus.torus_last = torus[N-1];

  int n_chk = 0, n_pass = 0;

  // Reference model state.
  int           m_mode, m_left, m_cnt, m_gen;
  bit           m_recirc, e_ena, e_step, e_busy, e_done;
  logic [15:0]  m_lfsr;
  logic [N-1:0] exp_torus = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  function automatic logic src_bit();
`ifdef LIFE_CTRL_LFSR_EN
    return m_lfsr[0];
`else
    return bus.ext_seed;
`endif
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_left = 0; m_cnt = 0; m_gen = 0; m_recirc = 0;
    e_ena = 0; e_step = 0; e_busy = 0; e_done = 0; m_lfsr = 16'hACE1;
  endtask

  task automatic start_load();
    m_mode = M_LOAD; m_left = N; m_recirc = bus.recirc;
    if (!bus.recirc) m_gen = 0;
    e_ena = 1; e_busy = 1;
  endtask

  // One clock edge of the spec's behaviour, using inputs as seen at the edge.
  task automatic model_step();
    int per;
    if (e_ena) exp_torus = {exp_torus[N-2:0], m_recirc ? torus[N-1] : src_bit()};
    if (e_ena && !m_recirc) m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    e_step = 0; e_done = 0;
    case (m_mode)
      M_IDLE:
        if (bus.load_req) start_load();
        else if (bus.run) begin m_mode = M_RUN; m_cnt = 0; end
        else if (bus.step_req) begin e_step = 1; m_gen = (m_gen + 1) % (1 << GEN_W); end
      M_LOAD: begin
        m_left--;
        if (m_left == 0) begin
          e_ena = 0; e_busy = 0; e_done = 1; m_cnt = 0;
          m_mode = bus.run ? M_RUN : M_IDLE;
        end
      end
      default:
        if (bus.load_req) start_load();
        else if (!bus.run) m_mode = M_IDLE;
        else begin
          per = (bus.period == 0) ? 1 : int'(bus.period);
          m_cnt++;
          if (m_cnt >= per) begin e_step = 1; m_cnt = 0; m_gen = (m_gen + 1) % (1 << GEN_W); end
        end
    endcase
  endtask

  // Advance one clock, update the model at the edge, compare at the falling edge.
  task automatic cycle();
    @(posedge gclk);
    if (!grst_n) model_reset(); else model_step();
    @(negedge gclk);
    chk("seed_ena", bus.seed_ena, e_ena);
    chk("life_step", bus.life_step, e_step);
    chk("busy", bus.busy, e_busy);
    chk("load_done", bus.load_done, e_done);
    chk("gen_count", bus.gen_count, m_gen);
    chk("seed", bus.seed, m_recirc ? torus[N-1] : src_bit());
    chk("excl", bus.seed_ena & bus.life_step, 0);
  endtask

  logic [N-1:0] snap;

  initial begin
    bus.load_req = 0; bus.recirc = 0; bus.ext_seed = 0; bus.run = 0;
    bus.step_req = 0; bus.period = '0;
    model_reset();
    repeat (2) @(negedge gclk);
    chk("rst_seed_ena", bus.seed_ena, 0);
    chk("rst_life_step", bus.life_step, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_gen", bus.gen_count, 0);
    grst_n = 1;

    // Fresh load with 1010... pattern.
    bus.load_req = 1; bus.recirc = 0; bus.ext_seed = 1;
    cycle();
    bus.load_req = 0;
    for (int i = 0; i < N + 2; i++) begin
      bus.ext_seed = ~bus.ext_seed;
      bus.step_req = (i == 5);   // ignored mid-load
      cycle();
    end
    bus.step_req = 0;
    chk("torus_fresh", torus, exp_torus);

    // Free-run period 3, then period 0, then stop.
    bus.run = 1; bus.period = 3;
    repeat (12) cycle();
    bus.period = 0;
    repeat (5) cycle();
    bus.run = 0;
    repeat (4) cycle();

    // Five single steps, then rotate: content and gen_count must survive.
    bus.load_req = 1; bus.recirc = 0;
    cycle();
    bus.load_req = 0;
    repeat (N + 1) begin bus.ext_seed = 1'($urandom); cycle(); end
    for (int i = 0; i < 5; i++) begin
      bus.step_req = 1; cycle();
      bus.step_req = 0; cycle();
    end
    chk("gen_five", bus.gen_count, 5);
    snap = torus;
    bus.load_req = 1; bus.recirc = 1;
    cycle();
    bus.load_req = 0; bus.recirc = 0;
    repeat (N + 2) cycle();
    chk("torus_rotate", torus, snap);
    chk("gen_kept", bus.gen_count, 5);

    // Asynchronous reset on cycle 7 of a load.
    bus.load_req = 1;
    cycle();
    bus.load_req = 0;
    repeat (6) cycle();
    grst_n = 0;
    #1;
    chk("arst_seed_ena", bus.seed_ena, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_gen", bus.gen_count, 0);
    chk("arst_step", bus.life_step, 0);
    model_reset();
    repeat (2) cycle();
    grst_n = 1;
    repeat (3) cycle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.load_req = ($urandom_range(0, 59) == 0);
      bus.recirc   = 1'($urandom);
      bus.ext_seed = 1'($urandom);
      bus.step_req = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) bus.run = ~bus.run;
      if ($urandom_range(0, 15) == 0) bus.period = DIV_W'($urandom_range(0, 5));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
